adder_tree_seq_ctrl: RTL and testbench



---
 rtl/adder_tree_pkg.sv | 62 ++++++
 rtl/adder_tree_seq_ctrl_tag_delay_line.sv | 52 +++++
 rtl/adder_tree_seq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_adder_tree_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
// Shared types and helpers for the adder-tree sequencing controller.
//   state_e      : controller FSM states (IDLE, FEED, DRAIN, OUT)
//   sat_res_t    : result of a saturating add (clamp flag + clamped value)
//   clog2_safe   : ceil(log2(n)), returns 0 for n <= 1
//   acc_width_f  : accumulator width that holds NUM_CHUNKS tree outputs
//   sat_add_f    : signed add clamped to a w-bit two's complement range
// -----------------------------------------------------------------------------
package adder_tree_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic               hit;
    logic signed [63:0] val;
  } sat_res_t;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int acc_width_f(input int width, input int chunks);
    return width + clog2_safe(chunks) + 1;
  endfunction

  // Operands arrive sign-extended to 64 bits, so the 64-bit sum is exact for
  // any w below 63 and only the clamp to the w-bit range is needed.
  function automatic sat_res_t sat_add_f(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int w);
    sat_res_t           res;
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (s > mx) begin
      res.hit = 1'b1;
      res.val = mx;
    end else if (s < mn) begin
      res.hit = 1'b1;
      res.val = mn;
    end else begin
      res.hit = 1'b0;
      res.val = s;
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_tree_seq_ctrl_tag_delay_line.sv
// -----------------------------------------------------------------------------
// tag_delay_line
// DEPTH-deep shift register carrying a valid bit and a first-of-reduction bit
// alongside data travelling through an external pipelined adder tree.
// DEPTH = 0 is a straight combinational bypass.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears all tags)
//   v_i, first_i      : tag entering alongside the tree input
//   v_o, first_o      : tag aligned with the tree output
// -----------------------------------------------------------------------------
module tag_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic v_i,
  input  logic first_i,
  output logic v_o,
  output logic first_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_s;
      assign unused_s = clk ^ reset;
      assign v_o      = v_i;
      assign first_o  = first_i;
    end else begin : g_pipe
      logic [DEPTH-1:0] v_q;
      logic [DEPTH-1:0] first_q;

      // Shift tags one stage per clock; reset drops anything in flight.
      always_ff @(posedge clk) begin
        if (reset) begin
          v_q     <= {DEPTH{1'b0}};
          first_q <= {DEPTH{1'b0}};
        end else begin
          v_q[0]     <= v_i;
          first_q[0] <= first_i;
          for (int i = 1; i < DEPTH; i++) begin
            v_q[i]     <= v_q[i-1];
            first_q[i] <= first_q[i-1];
          end
        end
      end

      assign v_o     = v_q[DEPTH-1];
      assign first_o = first_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/adder_tree_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_tree_seq_ctrl
// Feeds NUM_CHUNKS chunks of LEN elements through an external TREE_LAT-stage
// adder tree, accumulates the per-chunk tree results and hands out one sum.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_chunk : chunk input stream (element i at [WIDTH*i +: WIDTH])
//   tree_in_packed             : tree input (always equal to in_chunk)
//   tree_out                   : tree result, TREE_LAT cycles behind its input
//   out_valid/out_ready/out_sum: final sum output stream
//   busy                       : controller not in IDLE
//   chunk_idx                  : chunks accepted in the current reduction
//   sat_flag                   : sticky clamp flag (only with ADDER_TREE_SEQ_SAT_EN)
// Build option: define ADDER_TREE_SEQ_SAT_EN for a saturating accumulator;
// otherwise the accumulator wraps at ACC_WIDTH.
// -----------------------------------------------------------------------------
module adder_tree_seq_ctrl
  import adder_tree_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LEN        = 1024,
  parameter int NUM_CHUNKS = 4,
  parameter int TREE_LAT   = 2,
  parameter int ACC_WIDTH  = acc_width_f(WIDTH, NUM_CHUNKS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LEN*WIDTH-1:0]            in_chunk,
  output logic [LEN*WIDTH-1:0]            tree_in_packed,
  input  logic [WIDTH-1:0]                tree_out,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef ADDER_TREE_SEQ_SAT_EN
  output logic                            sat_flag,
`endif
  output logic [ACC_WIDTH-1:0]            out_sum,
  output logic                            busy,
  output logic [clog2_safe(NUM_CHUNKS):0] chunk_idx
);

  localparam int CIDX_W = clog2_safe(NUM_CHUNKS) + 1;
  localparam logic [CIDX_W-1:0] LAST_RES = CIDX_W'(NUM_CHUNKS - 1);
  localparam logic [CIDX_W-1:0] N_CHUNKS = CIDX_W'(NUM_CHUNKS);

  state_e                state_q, state_d;
  logic [CIDX_W-1:0]     chunk_idx_q, chunk_idx_d;
  logic [CIDX_W-1:0]     res_cnt_q, res_cnt_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  out_sum_q, out_sum_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic [ACC_WIDTH-1:0]  acc_ext_s, acc_next_s;
  logic                  acc_fire_s, res_valid_s, res_first_s, final_s;

  assign tree_in_packed = in_chunk;
  assign acc_fire_s     = in_valid & in_ready_q;
  assign acc_ext_s      = ACC_WIDTH'($signed(tree_out));
  assign final_s        = res_valid_s & (res_cnt_q == LAST_RES);

  tag_delay_line #(
    .DEPTH (TREE_LAT)
  ) u_tags (
    .clk     (clk),
    .reset   (reset),
    .v_i     (acc_fire_s),
    .first_i (chunk_idx_q == {CIDX_W{1'b0}}),
    .v_o     (res_valid_s),
    .first_o (res_first_s)
  );

`ifdef ADDER_TREE_SEQ_SAT_EN
  sat_res_t sat_r_s;
  logic     sat_hit_s;
  logic     sat_flag_q;

  // Saturating accumulate; the first chunk of a reduction only loads.
  always_comb begin
    sat_r_s    = sat_add_f(64'($signed(acc_q)), 64'($signed(acc_ext_s)), ACC_WIDTH);
    acc_next_s = acc_ext_s;
    sat_hit_s  = 1'b0;
    if (!res_first_s) begin
      acc_next_s = sat_r_s.val[ACC_WIDTH-1:0];
      sat_hit_s  = sat_r_s.hit;
    end else begin
      acc_next_s = acc_ext_s;
      sat_hit_s  = 1'b0;
    end
  end

  // Sticky clamp flag, cleared when the result is handed off.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag_q <= 1'b0;
    end else if ((state_q == ST_OUT) && out_ready) begin
      sat_flag_q <= 1'b0;
    end else if (res_valid_s && sat_hit_s) begin
      sat_flag_q <= 1'b1;
    end
  end

  assign sat_flag = sat_flag_q;
`else
  // Wrapping accumulate; the first chunk of a reduction only loads.
  always_comb begin
    acc_next_s = acc_ext_s;
    if (!res_first_s) begin
      acc_next_s = acc_q + acc_ext_s;
    end else begin
      acc_next_s = acc_ext_s;
    end
  end
`endif

  // Next-state logic: accumulator, counters, FSM and output registers.
  always_comb begin
    state_d     = state_q;
    chunk_idx_d = chunk_idx_q;
    res_cnt_d   = res_cnt_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;

    if (res_valid_s) begin
      acc_d     = acc_next_s;
      res_cnt_d = res_cnt_q + CIDX_W'(1);
    end else begin
      acc_d     = acc_q;
      res_cnt_d = res_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (acc_fire_s) begin
          chunk_idx_d = CIDX_W'(1);
          if (final_s) begin
            // Zero-latency tree with a single chunk: result is already here.
            out_sum_d   = acc_next_s;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else if (N_CHUNKS == CIDX_W'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (acc_fire_s) begin
          chunk_idx_d = chunk_idx_q + CIDX_W'(1);
          if (final_s) begin
            out_sum_d   = acc_next_s;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else if ((chunk_idx_q + CIDX_W'(1)) == N_CHUNKS) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (final_s) begin
          out_sum_d   = acc_next_s;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          chunk_idx_d = {CIDX_W{1'b0}};
          res_cnt_d   = {CIDX_W{1'b0}};
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_FEED);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      chunk_idx_q <= {CIDX_W{1'b0}};
      res_cnt_q   <= {CIDX_W{1'b0}};
      acc_q       <= {ACC_WIDTH{1'b0}};
      out_sum_q   <= {ACC_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_idx_q <= chunk_idx_d;
      res_cnt_q   <= res_cnt_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign busy      = (state_q != ST_IDLE);
  assign chunk_idx = chunk_idx_q;

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_seq_ctrl
// Directed bench: main instance LEN=4, WIDTH=16, NUM_CHUNKS=3, TREE_LAT=1 with
// a one-register tree model; second instance TREE_LAT=0, NUM_CHUNKS=1 with a
// combinational tree model.
// -----------------------------------------------------------------------------
module tb_adder_tree_seq_ctrl;

  localparam int W   = 16;
  localparam int L   = 4;
  localparam int ACW = 19;   // 16 + clog2(3) + 1
  localparam int AC0 = 17;   // 16 + clog2(1) + 1

  logic clk;
  logic reset;

  // main instance
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [L*W-1:0] in_chunk, tree_in_packed;
  logic [W-1:0]   tree_q;
  logic [ACW-1:0] out_sum;
  logic [2:0]     chunk_idx;

  // zero-latency single-chunk instance
  logic           in0_valid, in0_ready, out0_valid, out0_ready, busy0;
  logic [L*W-1:0] in0_chunk, tree0_in;
  logic [W-1:0]   tree0_s;
  logic [AC0-1:0] out0_sum;
  logic [0:0]     chunk0_idx;

`ifdef ADDER_TREE_SEQ_SAT_EN
  logic sat_flag, sat0_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  adder_tree_seq_ctrl #(.WIDTH(W), .LEN(L), .NUM_CHUNKS(3), .TREE_LAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_chunk(in_chunk), .tree_in_packed(tree_in_packed), .tree_out(tree_q),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef ADDER_TREE_SEQ_SAT_EN
    .sat_flag(sat_flag),
`endif
    .out_sum(out_sum), .busy(busy), .chunk_idx(chunk_idx)
  );

  adder_tree_seq_ctrl #(.WIDTH(W), .LEN(L), .NUM_CHUNKS(1), .TREE_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in0_valid), .in_ready(in0_ready),
    .in_chunk(in0_chunk), .tree_in_packed(tree0_in), .tree_out(tree0_s),
    .out_valid(out0_valid), .out_ready(out0_ready),
`ifdef ADDER_TREE_SEQ_SAT_EN
    .sat_flag(sat0_flag),
`endif
    .out_sum(out0_sum), .busy(busy0), .chunk_idx(chunk0_idx)
  );

  // Tree model: sum of the four elements, wrapping at WIDTH bits.
  function automatic logic [W-1:0] tree_sum(input logic [L*W-1:0] p);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < L; i++) s = s + p[W*i +: W];
    return s;
  endfunction

  always @(posedge clk) tree_q <= tree_sum(tree_in_packed);
  assign tree0_s = tree_sum(tree0_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [L*W-1:0] c);
    in_valid = v;
    in_chunk = c;
    step();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, then checks the latency in cycles.
  task automatic wait_out(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_val(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val({tag, "_ov_clr"}, 64'(out_valid), 64'sd0);
    check_val({tag, "_busy_clr"}, 64'(busy), 64'sd0);
    check_val({tag, "_idx_clr"}, 64'(chunk_idx), 64'sd0);
    check_val({tag, "_rdy_set"}, 64'(in_ready), 64'sd1);
  endtask

  localparam logic [63:0] ONES   = 64'h0001_0001_0001_0001;
  localparam logic [63:0] TWOS   = 64'h0002_0002_0002_0002;
  localparam logic [63:0] FIVES  = 64'h0005_0005_0005_0005;
  localparam logic [63:0] BIG    = 64'h3E80_3E80_3E80_3E80;   // 4 x 16000
  localparam logic [63:0] JUNK   = 64'h7FFF_7FFF_7FFF_7FFF;
  localparam logic [63:0] SG_A   = 64'h0000_0001_0001_FFFD;   // {-3,1,1,0}
  localparam logic [63:0] SG_B   = 64'hFFF8_FFFE_0005_0005;   // {5,5,-2,-8}
  localparam logic [63:0] SG_C   = 64'h0000_0000_0000_0007;   // {7,0,0,0}
  localparam logic [63:0] BB_A   = 64'h0004_0003_0002_0001;   // sum 10
  localparam logic [63:0] BB_B   = 64'h0028_001E_0014_000A;   // sum 100
  localparam logic [63:0] BB_C   = 64'hFFFF_FFFF_FFFF_FFFF;   // sum -4

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_chunk = '0; out_ready = 1'b0;
    in0_valid = 1'b0; in0_chunk = '0; out0_ready = 1'b0;
    step();
    step();
    check_val("rst_out_valid", 64'(out_valid), 64'sd0);
    check_val("rst_out_sum", 64'(out_sum), 64'sd0);
    check_val("rst_busy", 64'(busy), 64'sd0);
    check_val("rst_chunk_idx", 64'(chunk_idx), 64'sd0);
    check_val("rst_in_ready", 64'(in_ready), 64'sd0);
    reset = 1'b0;
    step();
    check_val("idle_in_ready", 64'(in_ready), 64'sd1);

    // Basic: three chunks of ones, back to back.
    drive(1'b1, ONES);
    drive(1'b1, ONES);
    check_val("basic_busy", 64'(busy), 64'sd1);
    drive(1'b1, ONES);
    check_val("basic_idx3", 64'(chunk_idx), 64'sd3);
    check_val("basic_drain_rdy", 64'(in_ready), 64'sd0);
    check_val("basic_ov_early", 64'(out_valid), 64'sd0);
    wait_out("basic_latency", 1);
    check_val("basic_sum", 64'($signed(out_sum)), 64'sd12);
    handshake("basic");

    // Signed chunks: -1 + 0 + 7.
    drive(1'b1, SG_A);
    drive(1'b1, SG_B);
    drive(1'b1, SG_C);
    wait_out("signed_latency", 1);
    check_val("signed_sum", 64'($signed(out_sum)), 64'sd6);
    handshake("signed");

    // Tree wraps 64000 to -1536 per chunk and is not corrected: 3 x -1536.
    drive(1'b1, BIG);
    drive(1'b1, BIG);
    drive(1'b1, BIG);
    wait_out("wrap_latency", 1);
    check_val("wrap_sum", 64'($signed(out_sum)), -64'sd4608);
    handshake("wrap");

    // Bubbles (1,0,0,1,0,1) with junk on the bus, then backpressure.
    drive(1'b1, BB_A);
    drive(1'b0, JUNK);
    drive(1'b0, JUNK);
    check_val("bub_idx1", 64'(chunk_idx), 64'sd1);
    drive(1'b1, BB_B);
    drive(1'b0, JUNK);
    drive(1'b1, BB_C);
    wait_out("bub_latency", 1);
    in_valid = 1'b1;
    in_chunk = JUNK;
    for (int i = 0; i < 5; i++) begin
      check_val("bub_hold_ov", 64'(out_valid), 64'sd1);
      check_val("bub_hold_sum", 64'($signed(out_sum)), 64'sd106);
      check_val("bub_hold_rdy", 64'(in_ready), 64'sd0);
      step();
    end
    check_val("bub_idx_hold", 64'(chunk_idx), 64'sd3);
    in_valid = 1'b0;
    handshake("bub");

    // Reset one cycle after the third accept: nothing comes out.
    drive(1'b1, FIVES);
    drive(1'b1, FIVES);
    drive(1'b1, FIVES);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mrst_ov", 64'(out_valid), 64'sd0);
    check_val("mrst_busy", 64'(busy), 64'sd0);
    check_val("mrst_idx", 64'(chunk_idx), 64'sd0);
    check_val("mrst_rdy", 64'(in_ready), 64'sd0);
    step();
    check_val("mrst_ov2", 64'(out_valid), 64'sd0);
    check_val("mrst_rdy2", 64'(in_ready), 64'sd1);
    drive(1'b1, TWOS);
    drive(1'b1, TWOS);
    drive(1'b1, TWOS);
    wait_out("after_rst_latency", 1);
    check_val("after_rst_sum", 64'($signed(out_sum)), 64'sd24);
    handshake("after_rst");

    // Zero-latency tree, single chunk: result on the next cycle.
    check_val("z_ov_idle", 64'(out0_valid), 64'sd0);
    check_val("z_rdy_idle", 64'(in0_ready), 64'sd1);
    in0_valid = 1'b1;
    in0_chunk = BB_A;
    step();
    in0_valid = 1'b0;
    check_val("z_ov", 64'(out0_valid), 64'sd1);
    check_val("z_sum", 64'($signed(out0_sum)), 64'sd10);
    check_val("z_busy", 64'(busy0), 64'sd1);
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;
    check_val("z_ov_clr", 64'(out0_valid), 64'sd0);
    check_val("z_busy_clr", 64'(busy0), 64'sd0);
    check_val("z_idx_clr", 64'(chunk0_idx), 64'sd0);

`ifdef ADDER_TREE_SEQ_SAT_EN
    check_val("sat_flag_clear", 64'(sat_flag), 64'sd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
